// File: rtl/mic_decim.sv
// Microphone front-end decimator: boxcar-averages 1/2/4/8 raw ADC samples
// and emits one truncated D_WIDTH sample per completed frame.
module mic_decim #(
   parameter int IN_WIDTH = 10,
   parameter int D_WIDTH  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                raw_valid,
   input  logic [IN_WIDTH-1:0] raw_sample,
   input  logic [1:0]          dec_sel,
   input  logic                clip_clr,
   output logic [D_WIDTH-1:0]  mic_signal,
   output logic                sample_valid,
   output logic                clip,
   output logic [2:0]          frame_cnt
);

   localparam int AW = IN_WIDTH + 3;
   localparam int SH = IN_WIDTH - D_WIDTH;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [AW-1:0]      acc_q, acc_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [1:0]         n_q, n_d;
   logic [D_WIDTH-1:0] mic_q, mic_d;
   logic               sv_q, sv_d;
   logic               clip_q, clip_d;

   logic               accept;
   logic               last;
   logic               hit;
   logic [1:0]         n_eff;
   logic [2:0]         n_m1;
   logic [AW-1:0]      sum;

   // The first sample of a frame uses dec_sel directly, so the factor
   // is effectively latched on that same edge.
   always_comb begin
      accept = (state_q == ACCUM) && en && raw_valid;
      n_eff  = (cnt_q == 3'd0) ? dec_sel : n_q;
      unique case (n_eff)
         2'd0:    n_m1 = 3'd0;
         2'd1:    n_m1 = 3'd1;
         2'd2:    n_m1 = 3'd3;
         default: n_m1 = 3'd7;
      endcase
      last = accept && (cnt_q == n_m1);
      sum  = acc_q + AW'(raw_sample);
      hit  = accept &&
             ((raw_sample == '0) || (raw_sample == '1));
   end

   always_comb begin
      state_d = en ? ACCUM : IDLE;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      mic_d   = mic_q;
      sv_d    = 1'b0;
      clip_d  = (clip_q & ~clip_clr) | hit;
      if ((state_q == IDLE) || !en) begin
         acc_d = '0;
         cnt_d = 3'd0;
      end else if (accept) begin
         if (cnt_q == 3'd0) begin
            n_d = dec_sel;
         end
         if (last) begin
            acc_d = '0;
            cnt_d = 3'd0;
            mic_d = D_WIDTH'(sum >> (32'(n_eff) + SH));
            sv_d  = 1'b1;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= 3'd0;
         n_q     <= 2'd0;
         mic_q   <= '0;
         sv_q    <= 1'b0;
         clip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         mic_q   <= mic_d;
         sv_q    <= sv_d;
         clip_q  <= clip_d;
      end
   end

   assign mic_signal   = mic_q;
   assign sample_valid = sv_q;
   assign clip         = clip_q;
   assign frame_cnt    = cnt_q;

endmodule

// File: tb/tb_mic_decim.sv
// Randomized bench for mic_decim against a frame-level averaging model.
module tb_mic_decim;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       raw_valid;
   logic [9:0] raw_sample;
   logic [1:0] dec_sel;
   logic       clip_clr;
   logic [7:0] mic_signal;
   logic       sample_valid;
   logic       clip;
   logic [2:0] frame_cnt;

   int errs = 0;
   int checks = 0;

   int q[$];
   int m_n = 1;
   bit m_active = 0;
   int exp_mic = 0;
   bit exp_sv = 0;
   bit exp_clip = 0;

   mic_decim #(.IN_WIDTH(10), .D_WIDTH(8)) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .raw_valid(raw_valid),
      .raw_sample(raw_sample),
      .dec_sel(dec_sel),
      .clip_clr(clip_clr),
      .mic_signal(mic_signal),
      .sample_valid(sample_valid),
      .clip(clip),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, predict, check at next negedge.
   task automatic cyc(input bit e, input bit rv, input int s,
                      input int sel, input bit clr);
      bit hit;
      int sum;
      en = e;
      raw_valid = rv;
      raw_sample = s[9:0];
      dec_sel = sel[1:0];
      clip_clr = clr;
      hit = 0;
      exp_sv = 0;
      if (m_active && e) begin
         if (rv) begin
            if (q.size() == 0) m_n = 1 << sel;
            q.push_back(s);
            if (s == 0 || s == 1023) hit = 1;
            if (q.size() == m_n) begin
               sum = 0;
               foreach (q[i]) sum += q[i];
               exp_mic = (sum / m_n) / 4;
               exp_sv = 1;
               q.delete();
            end
         end
      end else begin
         q.delete();
      end
      exp_clip = (exp_clip && !clr) || hit;
      m_active = e;
      @(posedge clk);
      @(negedge clk);
      chk("mic_signal", int'(mic_signal), exp_mic);
      chk("sample_valid", int'(sample_valid), int'(exp_sv));
      chk("clip", int'(clip), int'(exp_clip));
      chk("frame_cnt", int'(frame_cnt), q.size());
   endtask

   task automatic model_reset();
      q.delete();
      m_active = 0;
      exp_mic = 0;
      exp_sv = 0;
      exp_clip = 0;
   endtask

   int r;
   int s;

   initial begin
      rst = 1'b0;
      en = 1'b0;
      raw_valid = 1'b0;
      raw_sample = '0;
      dec_sel = '0;
      clip_clr = 1'b0;
      #1;
      chk("reset_mic", int'(mic_signal), 0);
      chk("reset_sv", int'(sample_valid), 0);
      chk("reset_clip", int'(clip), 0);
      chk("reset_cnt", int'(frame_cnt), 0);
      @(negedge clk);
      rst = 1'b1;

      // Averaging of 4: 1000/4 = 250, truncated to 8 bits = 62
      cyc(1, 0, 0, 2, 0);
      cyc(1, 1, 100, 2, 0);
      cyc(1, 1, 200, 2, 0);
      cyc(1, 1, 300, 2, 0);
      cyc(1, 1, 400, 2, 0);
      chk("avg4_mic", int'(mic_signal), 62);
      chk("avg4_sv", int'(sample_valid), 1);
      cyc(1, 0, 0, 2, 0);
      chk("avg4_sv_drop", int'(sample_valid), 0);

      // Pass-through with full-scale clip
      cyc(1, 1, 1023, 0, 0);
      chk("n1_hi", int'(mic_signal), 255);
      cyc(1, 1, 0, 0, 0);
      chk("n1_lo_mic", int'(mic_signal), 0);
      chk("n1_lo_sv", int'(sample_valid), 1);
      chk("clip_set", int'(clip), 1);
      cyc(1, 0, 0, 0, 1);
      chk("clip_clr", int'(clip), 0);
      // Clip event coinciding with clear keeps the flag
      cyc(1, 1, 1023, 0, 1);
      chk("clip_race", int'(clip), 1);
      cyc(1, 0, 0, 0, 1);

      // Eight-sample frame with gaps
      for (int i = 0; i < 8; i++) begin
         cyc(1, 1, 512, 3, 0);
         if (i < 7) cyc(1, 0, 0, 3, 0);
      end
      chk("avg8_mic", int'(mic_signal), 128);
      chk("avg8_cnt", int'(frame_cnt), 0);

      // Partial frame discarded by en dropping
      cyc(1, 1, 900, 2, 0);
      cyc(1, 1, 900, 2, 0);
      cyc(0, 0, 0, 2, 0);
      cyc(1, 0, 0, 2, 0);
      for (int i = 0; i < 4; i++) cyc(1, 1, 40, 2, 0);
      chk("discard_mic", int'(mic_signal), 10);

      // dec_sel change mid-frame applies to the next frame
      cyc(1, 1, 80, 1, 0);
      cyc(1, 1, 80, 2, 0);
      chk("latch_sv", int'(sample_valid), 1);
      for (int i = 0; i < 3; i++) cyc(1, 1, 160, 2, 0);
      chk("latch_cnt", int'(frame_cnt), 3);
      cyc(1, 1, 160, 2, 0);
      chk("latch_mic", int'(mic_signal), 40);

      // Asynchronous reset mid-frame
      cyc(1, 1, 300, 3, 0);
      cyc(1, 1, 300, 3, 0);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_mic", int'(mic_signal), 0);
      chk("arst_cnt", int'(frame_cnt), 0);
      chk("arst_clip", int'(clip), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      cyc(1, 0, 0, 1, 0);
      cyc(1, 1, 10, 1, 0);
      chk("arst_nosv", int'(sample_valid), 0);
      cyc(1, 1, 30, 1, 0);
      chk("arst_frame", int'(mic_signal), 5);

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            #2;
            rst = 1'b0;
            #1;
            chk("rnd_arst_sv", int'(sample_valid), 0);
            model_reset();
            @(negedge clk);
            rst = 1'b1;
         end
         s = $urandom_range(0, 1023);
         r = $urandom_range(0, 19);
         if (r == 0) s = 0;
         if (r == 1) s = 1023;
         cyc($urandom_range(0, 19) != 0, $urandom_range(0, 9) < 7, s,
             $urandom_range(0, 3), $urandom_range(0, 9) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
